// File: rtl/io_controller_gpio_pkg.sv
// Shared register-map constants for the memory-mapped GPIO controller.
// Build option: IO_DEBOUNCE_EN adds per-pin debounce filtering.
package io_pkg;

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_RISE_EN = 3'd4;
  localparam logic [2:0] REG_FALL_EN = 3'd5;

  localparam int REG_STRIDE = 8;
  localparam int MAX_PORTS  = 4;

endpackage

// File: rtl/io_controller_gpio_if.sv
// Register-bus bundle between memory_controller (master) and the GPIO block (slave).
interface io_controller_gpio_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           data_in;
  logic                  we;
  logic                  chip_select;
  logic [31:0]           data_out;

  modport master (output address, data_in, we, chip_select, input data_out);
  modport slave  (input address, data_in, we, chip_select, output data_out);
endinterface

// File: rtl/io_controller_gpio_pin_filter.sv
// Per-pin input path: two-flop synchroniser, optional debounce (IO_DEBOUNCE_EN),
// previous-value flop and qualified rise/fall detection.
module io_pin_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("io_pin_filter: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q, prev_q, first_q;
  logic filt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= filt;
      first_q <= 1'b0;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // The counter tracks consecutive disagreeing cycles; the DEBOUNCE_CYCLES-th one commits.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  assign filt_o = filt;
  assign rise_o = ~first_q &  filt & ~prev_q;
  assign fall_o = ~first_q & ~filt &  prev_q;

endmodule

// File: rtl/io_controller_gpio.sv
// Memory-mapped GPIO controller: per-port OUT/DIR/IN/EDGE_STATUS/RISE_EN/FALL_EN
// registers, word-offset decode and a registered interrupt. Option: IO_DEBOUNCE_EN.
module io_controller_gpio
  import io_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int PORT_WIDTH      = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  io_controller_gpio_if.slave             bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] io_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] io_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] io_oe,
  output logic                            irq
);

  localparam int PW    = PORT_WIDTH;
  localparam int NPINS = NUM_PORTS * PORT_WIDTH;

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS || PW < 1 || PW > 32 || ADDR_WIDTH < 5)
  begin : g_bad_params
    $error("io_controller_gpio: illegal parameter combination");
  end

  logic [1:0]       portSel;
  logic [2:0]       regSel;
  logic             portOk, wrEn, irq_q;
  logic [PW-1:0]    wrData;
  logic [NPINS-1:0] filt, rise, fall;
  logic [PW-1:0]    readVal [MAX_PORTS];
  logic [MAX_PORTS-1:0] statAny;
  logic             unusedData;

  assign portSel    = bus.address[4:3];
  assign regSel     = bus.address[2:0];
  assign portOk     = ({30'd0, portSel} < NUM_PORTS);
  assign wrEn       = bus.chip_select & bus.we & portOk;
  assign wrData     = bus.data_in[PW-1:0];
  assign unusedData = ^bus.data_in;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    io_pin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .pin_i  (io_in[i]),
      .filt_o (filt[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  for (genvar p = 0; p < MAX_PORTS; p++) begin : g_port
    if (p < NUM_PORTS) begin : g_live
      logic [PW-1:0] out_q, out_d, dir_q, dir_d, stat_q, stat_d;
      logic [PW-1:0] riseEn_q, riseEn_d, fallEn_q, fallEn_d;
      logic [PW-1:0] setMask, clrMask;
      logic          hit;

      assign hit     = wrEn && (portSel == 2'(p));
      assign setMask = (rise[p*PW +: PW] & riseEn_q) | (fall[p*PW +: PW] & fallEn_q);

      // A fresh edge event beats a simultaneous write-1-to-clear on the same bit.
      always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        riseEn_d = riseEn_q;
        fallEn_d = fallEn_q;
        clrMask  = '0;
        if (hit) begin
          case (regSel)
            REG_OUT:     out_d    = wrData;
            REG_DIR:     dir_d    = wrData;
            REG_STATUS:  clrMask  = wrData;
            REG_RISE_EN: riseEn_d = wrData;
            REG_FALL_EN: fallEn_d = wrData;
            default:     ;
          endcase
        end
        stat_d = (stat_q & ~clrMask) | setMask;
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_q    <= '0;
          dir_q    <= '0;
          stat_q   <= '0;
          riseEn_q <= '0;
          fallEn_q <= '0;
        end else begin
          out_q    <= out_d;
          dir_q    <= dir_d;
          stat_q   <= stat_d;
          riseEn_q <= riseEn_d;
          fallEn_q <= fallEn_d;
        end
      end

      assign io_out[p*PW +: PW] = out_q;
      assign io_oe[p*PW +: PW]  = dir_q;
      assign statAny[p]         = |stat_q;
      assign readVal[p] = (regSel == REG_OUT)     ? out_q :
                          (regSel == REG_DIR)     ? dir_q :
                          (regSel == REG_IN)      ? filt[p*PW +: PW] :
                          (regSel == REG_STATUS)  ? stat_q :
                          (regSel == REG_RISE_EN) ? riseEn_q :
                          (regSel == REG_FALL_EN) ? fallEn_q : '0;
    end else begin : g_absent
      assign statAny[p] = 1'b0;
      assign readVal[p] = '0;
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.chip_select && portOk) begin
      bus.data_out[PW-1:0] = readVal[portSel];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |statAny;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_io_controller_gpio.sv
// Self-checking bench for io_controller_gpio (NUM_PORTS=2, PORT_WIDTH=4); a history-based
// model is compared every cycle, and directed reads pin key values. Honours IO_DEBOUNCE_EN.
module tb_io_controller_gpio;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] io_in   = 8'h00;
  logic [7:0] io_out, io_oe;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  io_controller_gpio_if #(.ADDR_WIDTH(5)) bus ();

  io_controller_gpio #(
    .NUM_PORTS(2), .PORT_WIDTH(4), .ADDR_WIDTH(5), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                               input logic wr, input logic cs);
    bus.address     = addr;
    bus.data_in     = data;
    bus.we          = wr;
    bus.chip_select = cs;
    tick(1);
    bus.we          = 1'b0;
    bus.chip_select = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [4:0] addr,
                           input logic [31:0] expected);
    bus.address     = addr;
    bus.chip_select = 1'b1;
    bus.we          = 1'b0;
    #1;
    checkOutput(name, bus.data_out, expected);
  endtask

  // Model: IN is io_in as sampled two edges back; an edge event is a change between
  // consecutive IN values, latched into status at the following clock edge.
  logic [3:0] mOut [2], mDir [2], mStat [2], mRise [2], mFall [2];
  logic [7:0] h0, h1, h2;
  logic       mIrq;

  always @(posedge clock or negedge reset_n) begin : modelStep
    logic [7:0] rising, falling;
    logic [3:0] setv [2];
    logic [3:0] clr;
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        mOut[p] = 0; mDir[p] = 0; mStat[p] = 0; mRise[p] = 0; mFall[p] = 0;
      end
      h0 = 0; h1 = 0; h2 = 0; mIrq = 0;
    end else begin
      rising  = h1 & ~h2;
      falling = ~h1 & h2;
      mIrq    = (mStat[0] != 0) || (mStat[1] != 0);
      for (int p = 0; p < 2; p++) begin
        setv[p] = (rising[p*4 +: 4] & mRise[p]) | (falling[p*4 +: 4] & mFall[p]);
        clr = 0;
        if (bus.chip_select && bus.we && bus.address[4:3] == 2'(p)) begin
          case (bus.address[2:0])
            3'd0: mOut[p]  = bus.data_in[3:0];
            3'd1: mDir[p]  = bus.data_in[3:0];
            3'd3: clr      = bus.data_in[3:0];
            3'd4: mRise[p] = bus.data_in[3:0];
            3'd5: mFall[p] = bus.data_in[3:0];
            default: ;
          endcase
        end
        mStat[p] = (mStat[p] & ~clr) | setv[p];
      end
      h2 = h1; h1 = h0; h0 = io_in;
    end
  end

  function automatic logic [31:0] modelRead(input logic [4:0] a, input logic cs);
    logic [31:0] r;
    int p;
    r = 0;
    p = int'(a[4:3]);
    if (cs && p < 2) begin
      case (a[2:0])
        3'd0: r[3:0] = mOut[p];
        3'd1: r[3:0] = mDir[p];
        3'd2: r[3:0] = h1[p*4 +: 4];
        3'd3: r[3:0] = mStat[p];
        3'd4: r[3:0] = mRise[p];
        3'd5: r[3:0] = mFall[p];
        default: r = 0;
      endcase
    end
    return r;
  endfunction

`ifndef IO_DEBOUNCE_EN
  always @(negedge clock) begin
    checkOutput("cyc_io_out", {24'd0, io_out}, {24'd0, mOut[1], mOut[0]});
    checkOutput("cyc_io_oe", {24'd0, io_oe}, {24'd0, mDir[1], mDir[0]});
    checkOutput("cyc_irq", {31'd0, irq}, {31'd0, mIrq});
    checkOutput("cyc_data_out", bus.data_out, modelRead(bus.address, bus.chip_select));
  end
`endif

  initial begin
    bus.address     = '0;
    bus.data_in     = '0;
    bus.we          = 1'b0;
    bus.chip_select = 1'b0;

`ifdef IO_DEBOUNCE_EN
    tick(2);
    reset_n = 1'b1;
    tick(3);
    applyStimulus(5'd4, 32'h1, 1'b1, 1'b1);
    io_in = 8'h01;
    tick(3);
    io_in = 8'h00;
    tick(10);
    checkRead("db_short_in", 5'd2, 32'h0);
    checkRead("db_short_status", 5'd3, 32'h0);
    io_in = 8'h01;
    tick(6);
    checkRead("db_long_in", 5'd2, 32'h1);
    io_in = 8'h00;
    tick(2);
    checkRead("db_long_status", 5'd3, 32'h1);
`else
    io_in = 8'hFF;
    tick(2);
    applyStimulus(5'd0, 32'hF, 1'b1, 1'b1);
    checkOutput("rst_io_out", {24'd0, io_out}, 32'h0);
    checkOutput("rst_io_oe", {24'd0, io_oe}, 32'h0);
    checkRead("rst_data_out", 5'd2, 32'h0);
    reset_n = 1'b1;
    checkRead("in_cycle0", 5'd2, 32'h0);
    tick(1);
    checkRead("in_cycle1", 5'd2, 32'h0);
    tick(1);
    checkRead("in_cycle2", 5'd2, 32'hF);
    checkRead("in_port1", 5'd10, 32'hF);
    checkRead("status_after_rst", 5'd3, 32'h0);
    checkOutput("irq_after_rst", {31'd0, irq}, 32'h0);

    applyStimulus(5'd1, 32'hF, 1'b1, 1'b1);
    checkOutput("dir_to_pin", {28'd0, io_oe[3:0]}, 32'hF);
    applyStimulus(5'd0, 32'hA, 1'b1, 1'b1);
    checkOutput("out_to_pin", {28'd0, io_out[3:0]}, 32'hA);
    checkRead("read_out", 5'd0, 32'h0000_000A);
    applyStimulus(5'd0, 32'hFFFF_FFF5, 1'b1, 1'b1);
    checkRead("out_upper_ignored", 5'd0, 32'h5);
    applyStimulus(5'd2, 32'h0, 1'b1, 1'b1);
    checkRead("in_readonly", 5'd2, 32'hF);

    io_in = 8'h00;
    tick(3);
    applyStimulus(5'd12, 32'h1, 1'b1, 1'b1);
    io_in = 8'h10;
    tick(2);
    checkRead("p1_in_rise", 5'd10, 32'h1);
    checkRead("p1_status_early", 5'd11, 32'h0);
    tick(1);
    checkRead("p1_status_set", 5'd11, 32'h1);
    checkOutput("irq_not_yet", {31'd0, irq}, 32'h0);
    tick(1);
    checkOutput("irq_asserted", {31'd0, irq}, 32'h1);
    applyStimulus(5'd11, 32'h1, 1'b1, 1'b1);
    checkRead("p1_status_clr", 5'd11, 32'h0);
    checkOutput("irq_lingers", {31'd0, irq}, 32'h1);
    tick(1);
    checkOutput("irq_deasserted", {31'd0, irq}, 32'h0);

    applyStimulus(5'd4, 32'h1, 1'b1, 1'b1);
    io_in = 8'h11;
    tick(3);
    checkRead("p0_status_set", 5'd3, 32'h1);
    io_in = 8'h10;
    tick(3);
    io_in = 8'h11;
    tick(2);
    applyStimulus(5'd3, 32'h1, 1'b1, 1'b1);
    checkRead("collision_set_wins", 5'd3, 32'h1);
    checkOutput("collision_irq", {31'd0, irq}, 32'h1);
    applyStimulus(5'd4, 32'h0, 1'b1, 1'b1);
    checkRead("enable_off_keeps", 5'd3, 32'h1);
    applyStimulus(5'd3, 32'h1, 1'b1, 1'b1);
    checkRead("p0_status_clr", 5'd3, 32'h0);
    tick(1);
    checkOutput("irq_final_clear", {31'd0, irq}, 32'h0);

    applyStimulus(5'd16, 32'hF, 1'b1, 1'b1);
    checkRead("absent_port_read", 5'd16, 32'h0);
    checkRead("out_unchanged", 5'd0, 32'h5);
    checkRead("dir_unchanged", 5'd1, 32'hF);
    applyStimulus(5'd6, 32'hF, 1'b1, 1'b1);
    checkRead("reserved_read", 5'd6, 32'h0);
    bus.address     = 5'd0;
    bus.chip_select = 1'b0;
    #1;
    checkOutput("cs_low_read", bus.data_out, 32'h0);

    applyStimulus(5'd13, 32'h1, 1'b1, 1'b1);
    io_in = 8'h01;
    tick(3);
    checkRead("p1_fall_status", 5'd11, 32'h1);
    tick(1);
    checkOutput("irq_on_fall", {31'd0, irq}, 32'h1);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_controller_gpio.md
Name: io_controller_gpio

Overview:
Parametrised memory-mapped GPIO controller that replaces the fixed 4-bit bidirectional I/O port in the I/O window (0x0020-0x003F) of memory_controller.
- Provides NUM_PORTS independent ports of PORT_WIDTH pins each.
- Each port has output data, per-pin direction, a synchronised input view, and rise/fall edge capture with an aggregated interrupt.
- memory_controller decodes the window and drives chip_select. This block decodes the word offset.

Parameters:
NUM_PORTS, 2, number of GPIO ports; legal range 1-4 (each port occupies 8 words of the 32-word window).
PORT_WIDTH, 4, pins per port; legal range 1-32.
ADDR_WIDTH, 5, word-offset bits taken from the system address.
DEBOUNCE_CYCLES, 4, stable cycles required before an input change is accepted; used only with IO_DEBOUNCE_EN.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  ADDR_WIDTH  word offset within the I/O window.
data_in  input  32  write data.
we  input  1  write enable; qualified by chip_select.
chip_select  input  1  I/O window selected.
data_out  output  32  read data; combinational from address and register state.
io_in  input  NUM_PORTS*PORT_WIDTH  pin inputs; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
io_out  output  NUM_PORTS*PORT_WIDTH  pin output values.
io_oe  output  NUM_PORTS*PORT_WIDTH  per-pin output enable; 1 = drive.
irq  output  1  registered interrupt request.

Behaviour:
- Address decode: port = address[4:3], reg = address[2:0].
- Register map per port:
  - 0 OUT (rw)
  - 1 DIR (rw)
  - 2 IN (ro)
  - 3 EDGE_STATUS (write-1-to-clear)
  - 4 RISE_EN (rw)
  - 5 FALL_EN (rw)
  - 6-7 reserved
- Reserved offsets and ports >= NUM_PORTS:
  - Writes are ignored.
  - Reads return 0.
- Register width:
  - Only bits [PORT_WIDTH-1:0] are stored.
  - Upper read bits are 0.
  - Upper write bits are ignored.
- Write: occurs on the rising edge when chip_select && we. A write to IN is ignored.
- Read: data_out is valid in the same cycle as address.
  - data_out = 0 when chip_select is low.
  - A read has no side effects.
- Outputs: io_out = OUT and io_oe = DIR, taken directly from registers. There is 1 cycle from a write to the pin.
- Input path per pin:
  - Two-flop synchroniser, sync2 <= sync1 <= io_in.
  - filt = sync2 in the default build.
  - IN reads filt regardless of DIR.
  - A pin change sampled at edge k is visible in IN after edge k+1.
- Edge detect:
  - prev <= filt every cycle.
  - rise = filt & ~prev; fall = ~filt & prev.
  - EDGE_STATUS bit is set at the next edge when (rise & RISE_EN) | (fall & FALL_EN).
  - Status bit sets 1 cycle after IN changes.
- Clear/set collision: when a W1C write and a set event hit the same bit in the same cycle, the set wins. Other written-1 bits clear.
- Interrupt enables: clearing RISE_EN or FALL_EN does not clear pending status.
- irq <= OR over all ports of EDGE_STATUS, registered.
  - irq asserts 1 cycle after a status bit sets.
  - irq deasserts 1 cycle after the last status bit clears.
- Reset (asynchronous, any time, including mid-write):
  - OUT, DIR, EDGE_STATUS, RISE_EN, FALL_EN, sync1, sync2, prev and irq all go to 0.
  - Therefore io_out = 0, io_oe = 0 (all pins are inputs) and data_out = 0.
  - No edge event is generated on the first cycle after reset even if a pin is high: prev is loaded from filt, and detection is suppressed for one cycle by a registered first-cycle flag.

Optional Feature:
Macro IO_DEBOUNCE_EN.
- Defined:
  - Each pin has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While sync2 != filt, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, filt <= sync2 and the counter is reset to 0.
  - Any cycle with sync2 == filt resets the counter.
  - Pulses shorter than DEBOUNCE_CYCLES are never seen in IN or EDGE_STATUS.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - Counters and filt reset to 0.
- Undefined: filt = sync2, no counters exist, and DEBOUNCE_CYCLES is unused.

Decomposition:
- Package io_pkg holds:
  - register offset constants: REG_OUT=0, REG_DIR=1, REG_IN=2, REG_STATUS=3, REG_RISE_EN=4, REG_FALL_EN=5
  - REG_STRIDE=8
  - MAX_PORTS=4
- Sub-module io_pin_filter, one instance per pin:
  - contains the synchroniser, the optional debounce counter, the prev flop and the rise/fall outputs
  - is instantiated with a generate loop
- Top level holds the register file, decode and irq.

Test Plan:
- Reset with io_in all 1 → IN reads 0x0 for 2 cycles, then 0xF; EDGE_STATUS stays 0; irq stays 0; io_oe = 0.
- Write DIR(port0)=0xF and OUT(port0)=0xA at offsets 1 and 0 → io_oe[3:0]=0xF and io_out[3:0]=0xA one cycle after each write; read offset 0 returns 0x0000000A.
- RISE_EN(port1)=0x1, then io_in[4] 0→1 → IN(port1)=0x1 after 2 edges; EDGE_STATUS(port1)=0x1 at the next edge; irq=1 one cycle later. Write 0x1 to offset 11 → status=0, then irq=0 one cycle later.
- W1C on offset 3 in the same cycle as a new rising edge on that bit → bit remains 1 and irq stays high.
- Write offset 16 (port 2 with NUM_PORTS=2), then read it → reads 0 and no register changes; read with chip_select=0 → data_out=0.
- With IO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - a 3-cycle high pulse on io_in[0] → IN and status unchanged;
  - a 6-cycle pulse → IN=1 and the rise status sets.
